wb_stage: RTL and testbench
===========================

# wb_stage

MEM/WB pipeline register and writeback unit of the RV32I 5-stage pipeline. It latches the result of the MEM stage, aligns and extends load data, selects the writeback value and drives the register file write port (`we3`, `ad3`, `wd3`). The register file writes on the falling edge. A value presented here in one cycle is therefore readable by ID in the second half of the following cycle. The block also owns the 64-bit retired-instruction counter.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `INSTRET_W`, 64, width of the retire counter.

- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset (sampled on rising `clk`).
- `stall`  in  1  hold the MEM/WB register contents.
- `flush`  in  1  load a bubble into the MEM/WB register.
- `m_valid`  in  1  the MEM stage holds a real instruction.
- `m_reg_write`  in  1  the instruction writes `rd`.
- `m_rd`  in  5  destination register.
- `m_wb_sel`  in  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 treated as ALU.
- `m_funct3`  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `m_alu_result`  in  XLEN  ALU result; also the load address (bits [1:0] are the byte offset).
- `m_load_data`  in  XLEN  raw aligned word from data memory, little-endian.
- `m_pc_plus4`  in  XLEN  link value.
- `we3`  out  1  register file write enable.
- `ad3`  out  5  register file write address.
- `wd3`  out  XLEN  register file write data; also serves as the forwarding source.
- `load_misaligned`  out  1  the held instruction is a faulting load.
- `instret`  out  INSTRET_W  count of retired instructions.

## Operation
- **Register priority per rising edge:** reset > flush > stall > capture.
- **Capture:** the held fields are `valid_q`, `reg_write_q`, `rd_q`, `misaligned_q` and `wdata_q`. The writeback value is computed combinationally from the `m_*` inputs and registered. No mux sits after the flop, so `wd3` = `wdata_q`.
- **Load alignment** (applies only when `m_wb_sel`=01), with offset `off` = `m_alu_result[1:0]`:
  - LB / LBU: select byte `m_load_data[8*off+7 : 8*off]`; LB sign-extends, LBU zero-extends.
  - LH / LHU: select halfword `m_load_data[16*off[1]+15 : 16*off[1]]`; LH sign-extends, LHU zero-extends. If `off[0]`=1 the load is misaligned.
  - LW: whole word. If `off`≠0 the load is misaligned.
  - `funct3` values 011, 110, 111 are treated as misaligned.
- **Misaligned condition:** the misaligned flag is set only for loads (`m_wb_sel`=01). When it is set, the captured `wdata_q` is 0.
- **Flush / reset bubble:** `valid_q`=0, `reg_write_q`=0, `rd_q`=0, `misaligned_q`=0, `wdata_q`=0.
- **Stall:** all fields hold. `we3` stays asserted if it was asserted, so the write repeats with the same data, which is harmless.
- **Write port:**
  - `we3` = `valid_q` & `reg_write_q` & (`rd_q`≠0) & ~`misaligned_q`.
  - `ad3` = `rd_q`.
  - Writes to x0 are never issued.
- **Fault flag:** `load_misaligned` = `valid_q` & `misaligned_q`. It is level, held for as long as the entry is held.
- **Retire counter:** `instret` increments by 1 on each rising edge where `valid_q`=1, `misaligned_q`=0 and `stall`=0.
  - A stalled entry is therefore counted exactly once, when it leaves.
  - The counter wraps from all-ones to 0.
  - Only reset clears it; flush does not.

## Timing
- **Reset values:** while `rst`=0 at a rising edge, all outputs go to 0: `we3`=0, `ad3`=0, `wd3`=0, `load_misaligned`=0, `instret`=0. There is no asynchronous path.
- **Latency:** MEM inputs at edge N appear on `we3`/`ad3`/`wd3` after edge N. The register file commits the write on the falling edge in the middle of cycle N+1.
- **Throughput:** one instruction per cycle when not stalled.
- **`flush` and `stall` together:** flush wins; a bubble is loaded. `instret` still counts the outgoing valid entry, because `stall`=0 is not required for a flush-driven exit. Rule: the counter increments when `valid_q`=1, `misaligned_q`=0 and (`stall`=0 or `flush`=1).
- **Reset mid-stall:** the entry is discarded and not counted.
- **Timing path:** no combinational path from any `m_*` input to any output.

## Test plan
- **ALU writeback:** `m_valid`=1, `m_reg_write`=1, `m_rd`=5, `m_wb_sel`=00, `m_alu_result`=0x1234_5678 → next cycle `we3`=1, `ad3`=5, `wd3`=0x1234_5678, and `instret` +1 one edge later.
- **Load extension:** `m_load_data`=0x80FF_7F01 with LB at `off`=3 → `wd3`=0xFFFF_FF80; LBU at `off`=3 → 0x0000_0080; LH at `off`=2 → 0xFFFF_80FF; LHU at `off`=0 → 0x0000_7F01; LW at `off`=0 → 0x80FF_7F01.
- **Misaligned load:** LW with `off`=2 → `we3`=0, `load_misaligned`=1, `wd3`=0, `instret` unchanged. LH with `off`=1 gives the same result.
- **x0 and link:** JAL with `m_rd`=0, `m_wb_sel`=10 → `we3`=0 and `instret` +1. The same instruction with `m_rd`=1 and `m_pc_plus4`=0x0000_0104 → `we3`=1, `wd3`=0x0000_0104.
- **Stall / flush:** hold `stall`=1 for 3 cycles with a valid entry → outputs constant and `instret` increments once, only after `stall` deasserts. Assert `flush`+`stall` together → bubble on the next cycle (`we3`=0).
- **Reset and wrap:** preset `instret` to all-ones by forcing it, or by running with INSTRET_W=4 for 16 retires → wraps to 0. Drive `rst`=0 mid-stream → on the next edge every output is 0; the in-flight entry is neither written nor counted.

Source files
------------

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM-stage result bundle and register-file write port of the writeback stage
interface wb_stage_if #(
  parameter int XLEN = 32
);
  logic            m_valid;
  logic            m_reg_write;
  logic [4:0]      m_rd;
  logic [1:0]      m_wb_sel;
  logic [2:0]      m_funct3;
  logic [XLEN-1:0] m_alu_result;
  logic [XLEN-1:0] m_load_data;
  logic [XLEN-1:0] m_pc_plus4;

  logic            we3;
  logic [4:0]      ad3;
  logic [XLEN-1:0] wd3;

  modport slave (
    input  m_valid, m_reg_write, m_rd, m_wb_sel, m_funct3,
           m_alu_result, m_load_data, m_pc_plus4,
    output we3, ad3, wd3
  );

  modport master (
    output m_valid, m_reg_write, m_rd, m_wb_sel, m_funct3,
           m_alu_result, m_load_data, m_pc_plus4,
    input  we3, ad3, wd3
  );
endinterface

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register, load alignment, writeback select and retire counter
module wb_stage #(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  wb_stage_if.slave            wb,
  output logic                 load_misaligned,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_LINK = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  logic                 valid_q,      valid_d;
  logic                 reg_write_q,  reg_write_d;
  logic [4:0]           rd_q,         rd_d;
  logic                 misaligned_q, misaligned_d;
  logic [XLEN-1:0]      wdata_q,      wdata_d;
  logic [INSTRET_W-1:0] instret_q,    instret_d;

  logic [1:0]      off;
  logic [XLEN-1:0] shifted;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] load_val;
  logic            load_mis;
  logic            retire;

  // Byte lane selection; the half lane only depends on off[1] since odd halves fault.
  always_comb begin
    off     = wb.m_alu_result[1:0];
    shifted = wb.m_load_data >> {off, 3'b000};
    ld_byte = shifted[7:0];
    ld_half = off[1] ? wb.m_load_data[31:16] : wb.m_load_data[15:0];
  end

  always_comb begin
    load_val = '0;
    load_mis = 1'b0;
    case (wb.m_funct3)
      F3_LB:   load_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_LBU:  load_val = {{(XLEN-8){1'b0}}, ld_byte};
      F3_LH: begin
        load_val = {{(XLEN-16){ld_half[15]}}, ld_half};
        load_mis = off[0];
      end
      F3_LHU: begin
        load_val = {{(XLEN-16){1'b0}}, ld_half};
        load_mis = off[0];
      end
      F3_LW: begin
        load_val = wb.m_load_data;
        load_mis = (off != 2'b00);
      end
      default: load_mis = 1'b1;
    endcase
  end

  always_comb begin
    valid_d      = wb.m_valid;
    reg_write_d  = wb.m_reg_write;
    rd_d         = wb.m_rd;
    misaligned_d = 1'b0;
    wdata_d      = wb.m_alu_result;
    case (wb_sel_e'(wb.m_wb_sel))
      WB_LOAD: begin
        misaligned_d = load_mis;
        wdata_d      = load_mis ? '0 : load_val;
      end
      WB_LINK: wdata_d = wb.m_pc_plus4;
      WB_ALU,
      WB_RSVD: wdata_d = wb.m_alu_result;
      default: wdata_d = wb.m_alu_result;
    endcase
  end

  // A flush-driven exit still retires the outgoing entry even while stalled.
  always_comb begin
    retire    = valid_q & ~misaligned_q & (~stall | flush);
    instret_d = retire ? instret_q + 1'b1 : instret_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      misaligned_q <= 1'b0;
      wdata_q      <= '0;
      instret_q    <= '0;
    end else begin
      instret_q <= instret_d;
      if (flush) begin
        valid_q      <= 1'b0;
        reg_write_q  <= 1'b0;
        rd_q         <= '0;
        misaligned_q <= 1'b0;
        wdata_q      <= '0;
      end else if (!stall) begin
        valid_q      <= valid_d;
        reg_write_q  <= reg_write_d;
        rd_q         <= rd_d;
        misaligned_q <= misaligned_d;
        wdata_q      <= wdata_d;
      end
    end
  end

  assign wb.we3          = valid_q & reg_write_q & (rd_q != 5'd0) & ~misaligned_q;
  assign wb.ad3          = rd_q;
  assign wb.wd3          = wdata_q;
  assign load_misaligned = valid_q & misaligned_q;
  assign instret         = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - randomized self-checking bench for wb_stage against a behavioural model
module tb_wb_stage;

  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          flush;
  logic          load_misaligned;
  logic [IW-1:0] instret;

  wb_stage_if #(.XLEN(32)) bus ();

  wb_stage #(.XLEN(32), .INSTRET_W(IW)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .wb              (bus.slave),
    .load_misaligned (load_misaligned),
    .instret         (instret)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model of the held entry and the retire count
  logic          e_v, e_rw, e_mis;
  logic [4:0]    e_rd;
  logic [31:0]   e_wd;
  logic [IW-1:0] cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_cap(output logic mis, output logic [31:0] wd);
    int unsigned off, b, h;
    off = bus.m_alu_result % 4;
    mis = 1'b0;
    wd  = bus.m_alu_result;
    if (bus.m_wb_sel == 2'd1) begin
      b = (bus.m_load_data >> (8 * off)) % 256;
      h = (bus.m_load_data >> (16 * (off / 2))) % 65536;
      case (bus.m_funct3)
        3'd0: wd = (b >= 128) ? b - 256 : b;
        3'd4: wd = b;
        3'd1: begin wd = (h >= 32768) ? h - 65536 : h; mis = (off % 2) == 1; end
        3'd5: begin wd = h; mis = (off % 2) == 1; end
        3'd2: begin wd = bus.m_load_data; mis = off != 0; end
        default: mis = 1'b1;
      endcase
      if (mis) wd = 32'd0;
    end else if (bus.m_wb_sel == 2'd2) begin
      wd = bus.m_pc_plus4;
    end
  endfunction

  task automatic tick();
    logic m;
    logic [31:0] w;
    @(posedge clk);
    if (!rst) begin
      e_v = 0; e_rw = 0; e_rd = 0; e_mis = 0; e_wd = 0; cnt = 0;
    end else begin
      if (e_v && !e_mis && (!stall || flush)) cnt = cnt + 1'b1;
      if (flush) begin
        e_v = 0; e_rw = 0; e_rd = 0; e_mis = 0; e_wd = 0;
      end else if (!stall) begin
        ref_cap(m, w);
        e_v = bus.m_valid; e_rw = bus.m_reg_write; e_rd = bus.m_rd; e_mis = m; e_wd = w;
      end
    end
    #1;
    check("we3", bus.we3, e_v && e_rw && (e_rd != 0) && !e_mis);
    check("ad3", bus.ad3, e_rd);
    check("wd3", bus.wd3, e_wd);
    check("load_misaligned", load_misaligned, e_v && e_mis);
    check("instret", instret, cnt);
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] ld, input logic [31:0] pc4);
    bus.m_valid = v; bus.m_reg_write = 1'b1; bus.m_rd = rd; bus.m_wb_sel = sel;
    bus.m_funct3 = f3; bus.m_alu_result = alu; bus.m_load_data = ld; bus.m_pc_plus4 = pc4;
  endtask

  logic [2:0]  lf3 [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
  logic [1:0]  loff[5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
  logic [31:0] lexp[5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
  logic [IW-1:0] s0;

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 5'd3, 2'd0, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
    tick(); tick();
    check("rst_we3", bus.we3, 0);
    check("rst_wd3", bus.wd3, 0);
    check("rst_instret", instret, 0);
    rst = 1'b1;

    drive(1'b1, 5'd5, 2'd0, 3'd0, 32'h1234_5678, 32'h0, 32'h0);
    tick();
    check("alu_we3", bus.we3, 1);
    check("alu_ad3", bus.ad3, 5);
    check("alu_wd3", bus.wd3, 32'h1234_5678);
    bus.m_valid = 1'b0;
    tick();
    check("alu_instret", instret, 1);

    foreach (lf3[i]) begin
      drive(1'b1, 5'd7, 2'd1, lf3[i], {30'h400, loff[i]}, 32'h80FF_7F01, 32'h0);
      tick();
      check($sformatf("load_ext_%0d", i), bus.wd3, lexp[i]);
    end

    drive(1'b1, 5'd8, 2'd1, 3'd2, 32'h0000_1002, 32'h80FF_7F01, 32'h0);
    tick();
    s0 = instret;
    check("lw_mis_we3", bus.we3, 0);
    check("lw_mis_flag", load_misaligned, 1);
    check("lw_mis_wd3", bus.wd3, 0);
    drive(1'b1, 5'd8, 2'd1, 3'd1, 32'h0000_1001, 32'h80FF_7F01, 32'h0);
    tick();
    check("lh_mis_flag", load_misaligned, 1);
    check("lh_mis_we3", bus.we3, 0);
    check("mis_instret", instret, s0);

    drive(1'b1, 5'd0, 2'd2, 3'd0, 32'h0, 32'h0, 32'h0000_0104);
    tick();
    check("jal_x0_we3", bus.we3, 0);
    s0 = instret;
    drive(1'b1, 5'd1, 2'd2, 3'd0, 32'h0, 32'h0, 32'h0000_0104);
    tick();
    check("jal_x0_instret", instret, s0 + 1'b1);
    check("jal_we3", bus.we3, 1);
    check("jal_wd3", bus.wd3, 32'h0000_0104);

    s0 = instret;
    stall = 1'b1;
    drive(1'b1, 5'd9, 2'd0, 3'd0, 32'h5555_AAAA, 32'h0, 32'h0);
    repeat (3) tick();
    check("stall_instret", instret, s0);
    check("stall_wd3", bus.wd3, 32'h0000_0104);
    stall = 1'b0;
    bus.m_valid = 1'b0;
    tick();
    check("stall_release_instret", instret, s0 + 1'b1);

    drive(1'b1, 5'd10, 2'd0, 3'd0, 32'h0BAD_F00D, 32'h0, 32'h0);
    tick();
    s0 = instret;
    stall = 1'b1; flush = 1'b1;
    tick();
    check("flush_stall_we3", bus.we3, 0);
    check("flush_stall_instret", instret, s0 + 1'b1);
    stall = 1'b0; flush = 1'b0;

    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 5'(i % 32), 2'd0, 3'd0, i, 32'h0, 32'h0);
      tick();
    end
    check("wrap_pre", instret, 6'd63);
    bus.m_valid = 1'b0;
    tick();
    check("wrap_zero", instret, 0);

    drive(1'b1, 5'd4, 2'd0, 3'd0, 32'h1, 32'h0, 32'h0);
    tick();
    stall = 1'b1;
    rst = 1'b0;
    tick();
    check("rst_mid_we3", bus.we3, 0);
    check("rst_mid_instret", instret, 0);
    rst = 1'b1; stall = 1'b0;

    for (int i = 0; i < 800; i++) begin
      rst   = ($urandom_range(0, 63) != 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      bus.m_valid      = ($urandom_range(0, 7) != 0);
      bus.m_reg_write  = ($urandom_range(0, 7) != 0);
      bus.m_rd         = 5'($urandom_range(0, 31));
      bus.m_wb_sel     = 2'($urandom_range(0, 3));
      bus.m_funct3     = 3'($urandom_range(0, 7));
      bus.m_alu_result = $urandom;
      bus.m_load_data  = $urandom;
      bus.m_pc_plus4   = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
